aes256_inv_key_sched: RTL and testbench
=======================================

# aes256_inv_key_sched

Sequential AES-256 key schedule for the decryption datapath. It expands a 256-bit cipher key into the 15 round keys at one 128-bit round key per clock and stores them. It then serves the keys in decryption order (last encryption key first) through a one-cycle registered read port. It sits upstream of the AddRoundKey/InvMixColumns round logic. With `EQUIV_INV=1` it also pre-applies InvMixColumns to the middle keys, as the equivalent inverse cipher requires.

## Interface
- `EQUIV_INV`, default 0: 0 = plain round keys; 1 = decryption rounds 1..13 are returned with InvMixColumns applied per 32-bit column.
- `clk`  input  1  rising-edge clock (single clock domain).
- `rst`  input  1  asynchronous, active-high reset.
- `key_in`  input  256  cipher key, byte 0 in bits [255:248]; sampled only on `key_load`.
- `key_load`  input  1  one-cycle pulse that starts expansion; accepted in any state.
- `busy`  output  1  high while expansion is in progress.
- `ready`  output  1  high once all 15 keys are stored and valid.
- `rd_en`  input  1  read request; ignored unless `ready`=1.
- `rd_round`  input  4  decryption round 0..14; returns encryption round key (14 - `rd_round`).
- `rk_out`  output  128  registered round key; holds its value between reads.
- `rk_valid`  output  1  one-cycle pulse, one cycle after an accepted read.

## Operation
- State machine with three states: IDLE, EXPAND, DONE.
  - IDLE -> EXPAND on `key_load`.
  - EXPAND -> DONE after key 14 is written.
  - DONE -> EXPAND on `key_load`.
  - `key_load` during EXPAND restarts the expansion from the new `key_in`; no key from the old key survives as valid.
- Load edge:
  - rk[0] <= `key_in`[255:128]; rk[1] <= `key_in`[127:0].
  - The working window W (previous two round keys, 8 words) <= `key_in`.
  - Index counter k <= 2.
- Each EXPAND cycle computes four words combinationally from W. Words are w0..w3 of the new key; p0..p7 are the window words.
  - temp = p7.
  - Even k: temp = SubWord(RotWord(p7)) ^ {Rcon, 24'h0}, with Rcon = 8'h01 << (k/2 - 1) (01, 02, 04, 08, 10, 20, 40).
  - Odd k: temp = SubWord(p7), with no rotation and no Rcon.
  - w0 = p0 ^ temp; w1 = p1 ^ w0; w2 = p2 ^ w1; w3 = p3 ^ w2.
  - rk[k] <= {w0, w1, w2, w3}; W <= {p4..p7, w0..w3}; k <= k + 1.
- SubWord uses four instances of the forward AES S-box (combinational).
- Read path: an accepted read (`rd_en` and `ready`) selects rk[14 - `rd_round`].
  - If `EQUIV_INV`=1 and 1 <= `rd_round` <= 13, each of the four columns passes through InvMixColumns (multipliers 0e/0b/0d/09 over GF(2^8), polynomial 0x11b) before the output register.
  - Rounds 0 and 14 are never transformed.
- `rd_round` > 14 on an accepted read: `rk_out` <= 0 and `rk_valid` still pulses.
- Reads while `ready`=0 are dropped: no `rk_valid`, `rk_out` unchanged.
- Reset: state IDLE; `busy`, `ready` and `rk_valid` = 0; `rk_out` = 0; k = 0. Storage array contents are don't-care; `ready`=0 gates them.

## Timing
- `key_load` sampled at edge E0. After E0: `busy`=1, `ready`=0.
- Edges E1..E13 write rk[2]..rk[14].
- At E13: state DONE, `busy`=0, `ready`=1. Total expansion latency is 13 cycles after the load edge.
- `key_load` and `rd_en` in the same cycle: the load wins. `ready` drops at that edge and the read is dropped.
- Read latency: request at edge N, `rk_out`/`rk_valid` valid after edge N+1. Back-to-back reads give one result per cycle.
- Critical path, EQUIV_INV=0: S-box plus a 4-word XOR chain.
- Critical path, EQUIV_INV=1: add the 15:1 128-bit mux and InvMixColumns on the read path. Both must close in one cycle.
- `rst` asserted mid-expansion: all outputs return to reset values immediately (asynchronous). After release, `key_load` is required again.

## Test plan
- FIPS-197 C.3 key 000102…1f, load, wait:
  - `ready` rises exactly 13 cycles after the load edge.
  - Read `rd_round`=0 -> `rk_out`=24fc79ccbf0979e9371ac23c6d68de36.
  - `rd_round`=12 -> a573c29fa176c498a97fce93a572c09c.
  - `rd_round`=14 -> 000102030405060708090a0b0c0d0e0f.
- Same key: reads at `rd_round`=0..14 back-to-back -> 15 consecutive `rk_valid` pulses, each key matching the software model. Then `rd_round`=15 -> `rk_out`=0 with `rk_valid`=1.
- Restart: load key A, pulse `key_load` with key B at cycle 6 of expansion -> `ready` stays 0 until 13 cycles after the second load. All keys match key B only.
- Read while not ready: `rd_en`=1 during EXPAND -> no `rk_valid`, `rk_out` unchanged. `rd_en` and `key_load` in the same cycle in DONE -> read dropped, `ready` falls.
- Async reset: assert `rst` at cycle 7 of expansion, between clock edges -> `busy`/`ready`/`rk_valid`/`rk_out` go to 0 before the next edge. A later reload produces correct keys.
- `EQUIV_INV`=1 with the FIPS-197 key:
  - `rd_round`=0 and `rd_round`=14 match the plain keys.
  - `rd_round`=1..13 equal the model's InvMixColumns(key) for every column.

Source files
------------

// File: rtl/aes256_inv_key_sched.sv
// AES-256 key expansion at one round key per clock. Keys are served in decryption order
// through a registered read port, with optional InvMixColumns for the equivalent inverse cipher.
module aes256_inv_key_sched #(
  parameter bit EQUIV_INV = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         ready,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic [127:0] rk_out,
  output logic         rk_valid
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 0e/0b/0d/09 built from x2, x4, x8 so each column shares one xtime chain per byte
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_key(input logic [127:0] k);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix_col(k[127-32*c -: 32]);
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     k_q;
  logic [255:0]   win_q;
  logic [127:0]   rk_mem [15];

  logic [31:0]    p [8];
  logic [31:0]    temp;
  logic [7:0]     rcon;
  logic [31:0]    w0, w1, w2, w3;

  logic           rd_acc_p0;
  logic [3:0]     rd_idx_p0;
  logic [127:0]   rd_key_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      if (key_load)              k_q <= 4'd2;
      else if (state_q == EXPAND) k_q <= k_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_load) state_d = EXPAND;
      EXPAND:  if (key_load) state_d = EXPAND;
               else if (k_q == 4'd14) state_d = DONE;
      DONE:    if (key_load) state_d = EXPAND;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == EXPAND);
  assign ready = (state_q == DONE);

  // Expansion stage: next round key from the two-key window
  always_comb begin
    for (int i = 0; i < 8; i++) p[i] = win_q[255-32*i -: 32];
    rcon = 8'h01 << (k_q[3:1] - 3'd1);
    if (!k_q[0]) temp = sub_word({p[7][23:0], p[7][31:24]}) ^ {rcon, 24'h0};
    else         temp = sub_word(p[7]);
    w0 = p[0] ^ temp;
    w1 = p[1] ^ w0;
    w2 = p[2] ^ w1;
    w3 = p[3] ^ w2;
  end

  always_ff @(posedge clk) begin
    if (key_load) begin
      rk_mem[0] <= key_in[255:128];
      rk_mem[1] <= key_in[127:0];
      win_q     <= key_in;
    end else if (state_q == EXPAND) begin
      rk_mem[k_q] <= {w0, w1, w2, w3};
      win_q       <= {win_q[127:0], w0, w1, w2, w3};
    end
  end

  // Read stage p0: select in decryption order, optional InvMixColumns on middle rounds
  always_comb begin
    rd_acc_p0 = rd_en && (state_q == DONE) && !key_load;
    rd_idx_p0 = 4'd14 - rd_round;
    rd_key_p0 = '0;
    if (rd_round <= 4'd14) begin
      rd_key_p0 = rk_mem[rd_idx_p0];
      if (EQUIV_INV && rd_round != 4'd0 && rd_round != 4'd14) rd_key_p0 = inv_mix_key(rd_key_p0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_valid <= 1'b0;
      rk_out   <= '0;
    end else begin
      rk_valid <= rd_acc_p0;
      if (rd_acc_p0) rk_out <= rd_key_p0;
    end
  end

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Bench for aes256_inv_key_sched: FIPS-197 word-level key expansion model, plain and
// equivalent-inverse instances side by side, directed scenarios plus random traffic.
module tb_aes256_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = 4'd0;
  logic         busy, ready, busy1, ready1;
  logic [127:0] rk_out0, rk_out1;
  logic         rk_valid0, rk_valid1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes256_inv_key_sched #(.EQUIV_INV(1'b0)) dut0 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .busy(busy), .ready(ready),
    .rd_en(rd_en), .rd_round(rd_round), .rk_out(rk_out0), .rk_valid(rk_valid0));

  aes256_inv_key_sched #(.EQUIV_INV(1'b1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .busy(busy1), .ready(ready1),
    .rd_en(rd_en), .rd_round(rd_round), .rk_out(rk_out1), .rk_valid(rk_valid1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] r1, r2, r3, r4;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    r1 = {inv[6:0], inv[7]};
    r2 = {r1[6:0], r1[7]};
    r3 = {r2[6:0], r2[7]};
    r4 = {r3[6:0], r3[7]};
    return inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw_m(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [14:0][127:0] expand_m(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [14:0][127:0] r;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)      t = subw_m({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
      else if (i % 8 == 4) t = subw_m(t);
      w[i] = w[i-8] ^ t;
    end
    for (int j = 0; j < 15; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  function automatic logic [31:0] imc_col_m(input logic [31:0] c);
    logic [7:0] base [4];
    logic [7:0] a [4];
    logic [7:0] b [4];
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    for (int r = 0; r < 4; r++) begin
      b[r] = 8'h00;
      for (int k = 0; k < 4; k++) b[r] = b[r] ^ gmul(base[(k - r + 4) % 4], a[k]);
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [127:0] imc_key_m(input logic [127:0] k);
    return {imc_col_m(k[127:96]), imc_col_m(k[95:64]), imc_col_m(k[63:32]), imc_col_m(k[31:0])};
  endfunction

  logic               m_busy = 1'b0;
  logic               m_ready = 1'b0;
  logic               m_vld = 1'b0;
  int                 m_cnt = 0;
  logic [127:0]       m_rk0 = '0;
  logic [127:0]       m_rk1 = '0;
  logic [14:0][127:0] m_keys = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_vld <= 1'b0; m_cnt <= 0;
      m_rk0 <= '0; m_rk1 <= '0;
    end else begin
      m_vld <= 1'b0;
      if (key_load) begin
        m_keys  <= expand_m(key_in);
        m_busy  <= 1'b1;
        m_ready <= 1'b0;
        m_cnt   <= 13;
      end else if (m_busy) begin
        if (m_cnt == 1) begin m_busy <= 1'b0; m_ready <= 1'b1; end
        m_cnt <= m_cnt - 1;
      end
      if (rd_en && m_ready && !key_load) begin
        m_vld <= 1'b1;
        if (rd_round > 4'd14) begin
          m_rk0 <= '0; m_rk1 <= '0;
        end else begin
          m_rk0 <= m_keys[14 - int'(rd_round)];
          m_rk1 <= (rd_round >= 4'd1 && rd_round <= 4'd13) ? imc_key_m(m_keys[14 - int'(rd_round)])
                                                          : m_keys[14 - int'(rd_round)];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 128'(busy), 128'(m_busy));
      check("ready", 128'(ready), 128'(m_ready));
      check("busy_eq", 128'(busy1), 128'(m_busy));
      check("ready_eq", 128'(ready1), 128'(m_ready));
      check("rk_valid", 128'(rk_valid0), 128'(m_vld));
      check("rk_valid_eq", 128'(rk_valid1), 128'(m_vld));
      check("rk_out", rk_out0, m_rk0);
      check("rk_out_eq", rk_out1, m_rk1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_count(input logic [255:0] key);
    int n;
    key_in = key; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    check("ready_latency", 128'(n), 128'(13));
  endtask

  task automatic read_lit(input logic [3:0] r, input logic [127:0] lit, input bit both);
    rd_en = 1'b1; rd_round = r;
    tick();
    rd_en = 1'b0;
    check("lit_rk_out", rk_out0, lit);
    check("lit_rk_valid", 128'(rk_valid0), 128'(1));
    if (both) check("lit_rk_out_eq", rk_out1, lit);
  endtask

  task automatic read_all();
    int nv = 0;
    for (int r = 0; r < 15; r++) begin
      rd_en = 1'b1; rd_round = 4'(r);
      tick();
      if (rk_valid0) nv++;
    end
    check("b2b_pulses", 128'(nv), 128'(15));
    rd_round = 4'd15;
    tick();
    rd_en = 1'b0;
    check("rd15_out", rk_out0, 128'(0));
    check("rd15_valid", 128'(rk_valid0), 128'(1));
  endtask

  initial begin
    logic [14:0][127:0] mk;
    for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
    check("model_sbox00", 128'(sb[8'h00]), 128'h63);
    check("model_sbox53", 128'(sb[8'h53]), 128'hed);
    check("model_imc", 128'(imc_col_m(32'h8e4da1bc)), 128'hdb135345);
    mk = expand_m(FIPS_KEY);
    check("model_rk14", mk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("model_rk2", mk[2], 128'ha573c29fa176c498a97fce93a572c09c);

    rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_ready", 128'(ready), 128'(0));
    check("reset_rk_out", rk_out0, 128'(0));
    rst = 1'b0;
    tick();

    // FIPS-197 key: latency and literal reads
    load_count(FIPS_KEY);
    read_lit(4'd0, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b1);
    read_lit(4'd12, 128'ha573c29fa176c498a97fce93a572c09c, 1'b0);
    read_lit(4'd14, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    read_all();

    // reads during expansion are dropped
    key_in = {8{$urandom}}; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    rd_en = 1'b1; rd_round = 4'd3;
    repeat (5) tick();
    check("rd_not_ready_valid", 128'(rk_valid0), 128'(0));
    rd_en = 1'b0;
    repeat (12) tick();
    check("ready_after_expand", 128'(ready), 128'(1));
    read_all();

    // load and read in the same cycle: load wins
    rd_en = 1'b1; rd_round = 4'd2; key_in = FIPS_KEY; key_load = 1'b1;
    tick();
    rd_en = 1'b0; key_load = 1'b0;
    check("collide_valid", 128'(rk_valid0), 128'(0));
    check("collide_ready", 128'(ready), 128'(0));

    // restart mid-expansion with a new key
    key_in = {8{$urandom}}; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (5) tick();
    load_count({8{$urandom}});
    read_all();

    // asynchronous reset mid-expansion
    read_lit(4'd1, m_keys[13], 1'b0);
    key_in = {8{$urandom}}; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_ready", 128'(ready), 128'(0));
    check("arst_valid", 128'(rk_valid0), 128'(0));
    check("arst_rk_out", rk_out0, 128'(0));
    check("arst_rk_out_eq", rk_out1, 128'(0));
    tick();
    rst = 1'b0;
    tick();
    load_count(FIPS_KEY);
    read_all();

    // random traffic
    for (int c = 0; c < 500; c++) begin
      key_load = ($urandom_range(0, 39) == 0);
      if (key_load) key_in = {8{$urandom}};
      rd_en    = 1'($urandom_range(0, 1));
      rd_round = 4'($urandom_range(0, 15));
      tick();
    end
    key_load = 1'b0; rd_en = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
